// File: rtl/com_tx_sched.sv
// com_tx_sched: round-robin share of one com_tx among NUM_CH FWFT byte FIFOs; `COM_TX_SCHED_SUM_EN adds a trailing SUM byte.
// Header on the wire 2 cycles after req; each byte held until tx_ready, FIFO popped only on accepted data bytes.
module com_tx_sched #(
  parameter int         NUM_CH = 4,
  parameter int         LEN_W  = 8,
  parameter logic [7:0] HEAD   = 8'hAA
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*LEN_W-1:0] len,
  input  logic [NUM_CH*8-1:0]     ch_data,
  output logic [NUM_CH-1:0]       ch_rd,
  output logic [NUM_CH-1:0]       gnt,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_HDR, S_CID, S_LEN, S_DATA, S_SUM, S_DONE
  } state_t;

`ifdef COM_TX_SCHED_SUM_EN
  localparam state_t AFTER_DATA = S_SUM;
`else
  localparam state_t AFTER_DATA = S_DONE;
`endif

  state_t           state, state_nxt;
  logic [CH_W-1:0]  ptr, ch_q, pick;
  logic             pick_vld;
  logic [LEN_W-1:0] len_q, cnt;
  logic [7:0]       len_byte, cid_byte;
  logic             acc;

  assign acc      = tx_valid & tx_ready;
  assign cid_byte = 8'(ch_q);

  if (LEN_W >= 8) begin : g_len_wide
    assign len_byte = len_q[7:0];
  end else begin : g_len_narrow
    assign len_byte = {{(8-LEN_W){1'b0}}, len_q};
  end

  // First requester at or above ptr, wrapping past the top channel.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pick_vld && req[(int'(ptr) + i) % NUM_CH]) begin
        pick     = CH_W'((int'(ptr) + i) % NUM_CH);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      ch_q  <= '0;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      if (state == S_ARB && pick_vld) begin
        ch_q  <= pick;
        len_q <= len[int'(pick)*LEN_W +: LEN_W];
      end
      if (state == S_ARB)
        cnt <= '0;
      else if (state == S_DATA && acc)
        cnt <= cnt + 1'b1;
      // Only a completed frame advances the pointer; reset returns it to 0.
      if (state == S_DONE)
        ptr <= (ch_q == CH_W'(NUM_CH-1)) ? '0 : ch_q + 1'b1;
    end
  end

`ifdef COM_TX_SCHED_SUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum <= '0;
    else if (state == S_ARB)
      sum <= '0;
    else if (acc && (state == S_CID || state == S_LEN || state == S_DATA))
      sum <= sum + tx_data;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (|req) state_nxt = S_ARB;
      S_ARB:  state_nxt = pick_vld ? S_HDR : S_IDLE;
      S_HDR:  if (tx_ready) state_nxt = S_CID;
      S_CID:  if (tx_ready) state_nxt = S_LEN;
      S_LEN:  if (tx_ready) state_nxt = (len_q != '0) ? S_DATA : AFTER_DATA;
      S_DATA: if (tx_ready && cnt == len_q - 1'b1) state_nxt = AFTER_DATA;
      S_SUM:  if (tx_ready) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt      = '0;
    ch_rd    = '0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    case (state)
      S_ARB: if (pick_vld) gnt[pick] = 1'b1;
      S_HDR: begin
        gnt[ch_q] = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = HEAD;
      end
      S_CID: begin
        gnt[ch_q] = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = cid_byte;
      end
      S_LEN: begin
        gnt[ch_q] = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = len_byte;
      end
      S_DATA: begin
        gnt[ch_q]   = 1'b1;
        tx_valid    = 1'b1;
        tx_data     = ch_data[int'(ch_q)*8 +: 8];
        ch_rd[ch_q] = tx_ready;
      end
`ifdef COM_TX_SCHED_SUM_EN
      S_SUM: begin
        gnt[ch_q] = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = sum;
      end
`endif
      default: ;
    endcase
  end

endmodule
